// File: rtl/i2c_addr_matcher_if.sv
// Bus bundle between the I2C address-phase engine and its environment.
// The raw pins and slot configuration go in; the match/ACK status comes out.
interface i2c_addr_matcher_if #(
    parameter int unsigned NUM_ADDR = 2
);
    logic                    scl;
    logic                    sda;
    logic                    enable;
    logic [NUM_ADDR*10-1:0]  own_addr;
    logic [NUM_ADDR*10-1:0]  addr_mask;
    logic [NUM_ADDR-1:0]     ten_bit;
    logic                    address_match;
    logic [2:0]              match_id;
    logic                    read_bit;
    logic                    write_bit;
    logic                    general_call;
    logic                    ack_drive;
    logic                    start_det;
    logic                    stop_det;
    logic                    busy;

    modport slave (
        input  scl, sda, enable, own_addr, addr_mask, ten_bit,
        output address_match, match_id, read_bit, write_bit, general_call,
               ack_drive, start_det, stop_det, busy
    );

    modport master (
        output scl, sda, enable, own_addr, addr_mask, ten_bit,
        input  address_match, match_id, read_bit, write_bit, general_call,
               ack_drive, start_det, stop_det, busy
    );
endinterface

// File: rtl/i2c_addr_matcher.sv
// I2C subordinate address-phase engine: oversampled START/STOP detection,
// multi-slot 7/10-bit address matching with masks, general call and address ACK.
module i2c_addr_matcher #(
    parameter int unsigned NUM_ADDR    = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          GEN_CALL_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    i2c_addr_matcher_if.slave bus
);
    localparam int unsigned AW = 10;
    localparam int unsigned BW = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned IW = 3;
    localparam logic [CW-1:0] BIT_LAST = CW'(8);

    typedef enum logic [2:0] {IDLE, BYTE1, ACK1, BYTE2, ACK2, MATCHED, IGNORE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_q, sda_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          shreg_q, shreg_d;
    logic [1:0]             a98_q, a98_d;
    logic                   ctx_valid_q, ctx_valid_d;
    logic [IW-1:0]          ctx_id_q, ctx_id_d;
    logic                   am_q, am_d, rd_q, rd_d, wr_q, wr_d, gc_q, gc_d;
    logic                   ack_q, ack_d, start_q, start_d, stop_q, stop_d, busy_q, busy_d;
    logic [IW-1:0]          id_q, id_d;

    logic scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c;
    logic hdr, gc_hit, m7_any, h10_any, f10_any, ctx_hit;
    logic [IW-1:0] m7_id, f10_id;
    logic [AW-1:0] own, msk;

    // Input synchronisers plus one edge-detect stage; idle bus level is high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda};
            scl_q    <= scl_sync[SYNC_STAGES-1];
            sda_q    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_q;
    assign scl_fall = ~scl_s & scl_q;
    assign start_c  = sda_q & ~sda_s & scl_s & scl_q;
    assign stop_c   = ~sda_q & sda_s & scl_s & scl_q;
    assign hdr      = (shreg_q[7:3] == 5'b11110);
    assign gc_hit   = GEN_CALL_EN && (shreg_q == 8'h00);

    // Per-slot comparisons; ascending scan with found flags so the lowest index wins
    always_comb begin
        m7_any  = 1'b0;
        m7_id   = '0;
        h10_any = 1'b0;
        f10_any = 1'b0;
        f10_id  = '0;
        ctx_hit = 1'b0;
        own     = '0;
        msk     = '0;
        for (int unsigned i = 0; i < NUM_ADDR; i++) begin
            own = bus.own_addr[AW*i +: AW];
            msk = bus.addr_mask[AW*i +: AW];
            if (!bus.ten_bit[i]) begin
                if (!m7_any && (((shreg_q[7:1] ^ own[6:0]) & ~msk[6:0]) == 7'd0)) begin
                    m7_any = 1'b1;
                    m7_id  = IW'(i);
                end
            end else begin
                if (((shreg_q[2:1] ^ own[9:8]) & ~msk[9:8]) == 2'd0) begin
                    h10_any = 1'b1;
                    if (ctx_valid_q && (ctx_id_q == IW'(i))) ctx_hit = 1'b1;
                end
                if (!f10_any && ((({a98_q, shreg_q} ^ own) & ~msk) == 10'd0)) begin
                    f10_any = 1'b1;
                    f10_id  = IW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            a98_q       <= '0;
            ctx_valid_q <= 1'b0;
            ctx_id_q    <= '0;
            am_q        <= 1'b0;
            id_q        <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            gc_q        <= 1'b0;
            ack_q       <= 1'b0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            a98_q       <= a98_d;
            ctx_valid_q <= ctx_valid_d;
            ctx_id_q    <= ctx_id_d;
            am_q        <= am_d;
            id_q        <= id_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            gc_q        <= gc_d;
            ack_q       <= ack_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        a98_d       = a98_q;
        ctx_valid_d = ctx_valid_q;
        ctx_id_d    = ctx_id_q;
        am_d        = am_q;
        id_d        = id_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        gc_d        = gc_q;
        ack_d       = ack_q;
        start_d     = 1'b0;
        stop_d      = 1'b0;
        busy_d      = busy_q;
        if (start_c || stop_c) begin
            // Bus conditions abort whatever is in progress; only STOP drops 10-bit context
            state_d = start_c ? (bus.enable ? BYTE1 : IGNORE) : IDLE;
            cnt_d   = '0;
            am_d    = 1'b0;
            id_d    = '0;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            gc_d    = 1'b0;
            ack_d   = 1'b0;
            start_d = start_c;
            stop_d  = stop_c;
            busy_d  = start_c;
            if (stop_c) ctx_valid_d = 1'b0;
        end else begin
            case (state_q)
                BYTE1, BYTE2: begin
                    if (scl_rise && (cnt_q < BIT_LAST)) begin
                        shreg_d = {shreg_q[BW-2:0], sda_s};
                        cnt_d   = cnt_q + CW'(1);
                    end else if (scl_fall && (cnt_q == BIT_LAST)) begin
                        cnt_d   = '0;
                        state_d = IGNORE;
                        if (state_q == BYTE1) begin
                            a98_d = shreg_q[2:1];
                            if (gc_hit) begin
                                state_d = ACK1;
                                ack_d   = 1'b1;
                                am_d    = 1'b1;
                                wr_d    = 1'b1;
                                gc_d    = 1'b1;
                            end else if (m7_any) begin
                                state_d = ACK1;
                                ack_d   = 1'b1;
                                am_d    = 1'b1;
                                id_d    = m7_id;
                                rd_d    = shreg_q[0];
                                wr_d    = ~shreg_q[0];
                            end else if (hdr && !shreg_q[0] && h10_any) begin
                                state_d = ACK1;
                                ack_d   = 1'b1;
                            end else if (hdr && shreg_q[0] && ctx_hit) begin
                                state_d = ACK1;
                                ack_d   = 1'b1;
                                am_d    = 1'b1;
                                id_d    = ctx_id_q;
                                rd_d    = 1'b1;
                            end
                        end else if (f10_any) begin
                            state_d     = ACK2;
                            ack_d       = 1'b1;
                            am_d        = 1'b1;
                            id_d        = f10_id;
                            wr_d        = 1'b1;
                            ctx_valid_d = 1'b1;
                            ctx_id_d    = f10_id;
                        end
                    end
                end
                ACK1, ACK2: begin
                    // cnt marks that the 9th SCL high phase has been seen
                    if (scl_rise) begin
                        cnt_d = CW'(1);
                    end else if (scl_fall && (cnt_q != '0)) begin
                        cnt_d   = '0;
                        ack_d   = 1'b0;
                        state_d = ((state_q == ACK1) && !am_q) ? BYTE2 : MATCHED;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.address_match = am_q;
    assign bus.match_id      = id_q;
    assign bus.read_bit      = rd_q;
    assign bus.write_bit     = wr_q;
    assign bus.general_call  = gc_q;
    assign bus.ack_drive     = ack_q;
    assign bus.start_det     = start_q;
    assign bus.stop_det      = stop_q;
    assign bus.busy          = busy_q;
endmodule

// File: tb/tb_i2c_addr_matcher.sv
// Directed bench for i2c_addr_matcher: a table of single-byte 7-bit/general-call
// transactions plus hand sequences for 10-bit, repeated START, overlap and reset.
module tb_i2c_addr_matcher;
    localparam int unsigned NA = 2;
    localparam int Q = 5;

    typedef struct {
        logic [7:0] b;
        logic       en;
        logic       ack;
        logic       am;
        logic [2:0] id;
        logic       rd;
        logic       wr;
        logic       gc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   n_start = 0;
    int   n_stop = 0;
    int   exp_start = 0;
    int   exp_stop = 0;
    logic s_ack, s_am, s_rd, s_wr, s_gc, s_busy;
    logic [2:0] s_id;
    vec_t vt [9];

    i2c_addr_matcher_if #(.NUM_ADDR(NA)) bus ();

    i2c_addr_matcher #(.NUM_ADDR(NA), .SYNC_STAGES(2), .GEN_CALL_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.scl = scl_m;
    assign bus.sda = sda_m & ~bus.ack_drive;

    always @(negedge clk) begin
        if (bus.start_det === 1'b1) n_start++;
        if (bus.stop_det === 1'b1) n_stop++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
        exp_start++;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
        exp_stop++;
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(2*Q);
        scl_m = 1'b0; tick(Q);
    endtask

    // Eight data bits then the ACK clock; status is sampled mid ACK-high
    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        s_ack  = bus.ack_drive;
        s_am   = bus.address_match;
        s_id   = bus.match_id;
        s_rd   = bus.read_bit;
        s_wr   = bus.write_bit;
        s_gc   = bus.general_call;
        s_busy = bus.busy;
        tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic chk_out(input string t, input logic ack, input logic am, input logic [2:0] id,
                           input logic rd, input logic wr, input logic gc);
        check({t, ".ack"}, 32'(s_ack), 32'(ack));
        check({t, ".match"}, 32'(s_am), 32'(am));
        check({t, ".id"}, 32'(s_id), 32'(id));
        check({t, ".rd"}, 32'(s_rd), 32'(rd));
        check({t, ".wr"}, 32'(s_wr), 32'(wr));
        check({t, ".gc"}, 32'(s_gc), 32'(gc));
    endtask

    task automatic chk_idle(input string t);
        check({t, ".idle_match"}, 32'(bus.address_match), 32'd0);
        check({t, ".idle_busy"}, 32'(bus.busy), 32'd0);
        check({t, ".idle_ack"}, 32'(bus.ack_drive), 32'd0);
        check({t, ".stop_cnt"}, 32'(n_stop), 32'(exp_stop));
        check({t, ".start_cnt"}, 32'(n_start), 32'(exp_start));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{8'hCE, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0};
        vt[1] = '{8'hCF, 1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0};
        vt[2] = '{8'h65, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0};
        vt[3] = '{8'h69, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        vt[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1};
        vt[5] = '{8'h01, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        vt[6] = '{8'hCE, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        vt[7] = '{8'h60, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0};
        vt[8] = '{8'h66, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0};

        bus.enable    = 1'b1;
        bus.own_addr  = {10'h030, 10'h067};
        bus.addr_mask = {10'h003, 10'h000};
        bus.ten_bit   = 2'b00;

        tick(4);
        check("rst.match", 32'(bus.address_match), 32'd0);
        check("rst.ack", 32'(bus.ack_drive), 32'd0);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.start", 32'(bus.start_det), 32'd0);
        check("rst.id", 32'(bus.match_id), 32'd0);
        rst = 1'b1;
        tick(4);

        // Single-byte 7-bit / general-call vectors
        for (int k = 0; k < 9; k++) begin
            string t;
            t = $sformatf("vec%0d", k);
            bus.enable = vt[k].en;
            i2c_start();
            send_byte(vt[k].b);
            chk_out(t, vt[k].ack, vt[k].am, vt[k].id, vt[k].rd, vt[k].wr, vt[k].gc);
            check({t, ".busy"}, 32'(s_busy), 32'd1);
            i2c_stop();
            tick(4);
            chk_idle(t);
        end
        bus.enable = 1'b1;

        // Repeated START after four bits restarts the byte
        i2c_start();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        i2c_start();
        send_byte(8'hCE);
        chk_out("sr_mid", 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
        i2c_stop();
        tick(4);
        chk_idle("sr_mid");

        // Overlapping slots: lowest index wins
        bus.own_addr  = {10'h000, 10'h067};
        bus.addr_mask = {10'h07F, 10'h000};
        i2c_start(); send_byte(8'hCE);
        chk_out("ovl0", 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
        i2c_stop(); tick(4);
        i2c_start(); send_byte(8'h10);
        chk_out("ovl1", 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0);
        i2c_stop(); tick(4);
        chk_idle("ovl");

        // 10-bit slot 0 = 0x2A5: write, Sr read, then context loss after STOP
        bus.own_addr  = {10'h030, 10'h2A5};
        bus.addr_mask = {10'h003, 10'h000};
        bus.ten_bit   = 2'b01;
        i2c_start();
        send_byte(8'hF4);
        chk_out("t10_hdr", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        send_byte(8'hA5);
        chk_out("t10_wr", 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
        i2c_start();
        send_byte(8'hF5);
        chk_out("t10_rd", 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
        i2c_stop(); tick(4);
        chk_idle("t10");
        i2c_start();
        send_byte(8'hF5);
        chk_out("t10_noctx", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        i2c_stop(); tick(4);
        i2c_start();
        send_byte(8'hF4);
        check("t10_bad.hdr_ack", 32'(s_ack), 32'd1);
        send_byte(8'hA4);
        chk_out("t10_bad", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        i2c_stop(); tick(4);

        // Reset asserted while ACKing the second 10-bit byte
        i2c_start();
        send_byte(8'hF4);
        for (int i = 7; i >= 0; i--) send_bit(1'((8'hA5 >> i) & 1));
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        check("rst_ack.before", 32'(bus.ack_drive), 32'd1);
        rst = 1'b0;
        #1;
        check("rst_ack.async", 32'(bus.ack_drive), 32'd0);
        check("rst_ack.match", 32'(bus.address_match), 32'd0);
        tick(3);
        rst = 1'b1;
        tick(Q);
        scl_m = 1'b0; tick(Q);
        i2c_start();
        send_byte(8'hF5);
        chk_out("rst_noctx", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        i2c_stop(); tick(4);
        chk_idle("rst_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
